// File: rtl/car_drive_pkg.sv
// Shared types for the car_drive elevator controller: floor codes, the
// reserved invalid code and the FSM state encoding.
package car_drive_pkg;

  localparam logic [1:0] LABEL_F1      = 2'b00;
  localparam logic [1:0] LABEL_F2      = 2'b01;
  localparam logic [1:0] LABEL_F3      = 2'b10;
  localparam logic [1:0] FLOOR_INVALID = 2'b11;

  // Position is tracked internally as an index 0..2 (F1..F3).
  localparam logic [1:0] IDX_F1 = 2'd0;
  localparam logic [1:0] IDX_F2 = 2'd1;
  localparam logic [1:0] IDX_F3 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE      = 2'd1,
    ST_DOOR_OPEN = 2'd2
  } state_e;

endpackage

// File: rtl/car_drive_interval_timer.sv
// Loadable 8-bit down-counter; done is high in the last cycle of a loaded
// interval, so a load of N produces done exactly N edges after the load.
module interval_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       done
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Holds at zero when idle so the counter never wraps.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 8'd1);

endmodule

// File: rtl/car_drive.sv
// Three-floor elevator car controller: accepts one command at a time in IDLE,
// steps one floor per travel interval, then holds the door open.
module car_drive
  import car_drive_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3,
  parameter logic [1:0]  labelF1       = LABEL_F1,
  parameter logic [1:0]  labelF2       = LABEL_F2,
  parameter logic [1:0]  labelF3       = LABEL_F3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_floor,
  output logic       cmd_ready,
  output logic       floor1,
  output logic       floor2,
  output logic       floor3,
  output logic       moving,
  output logic       dir_up,
  output logic       door,
  output logic       arrived,
  output logic       cmd_error
);

  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES);

  state_e     state_q, state_d;
  logic [1:0] pos_q, pos_d;
  logic [1:0] target_q, target_d;
  logic       dir_q, dir_d;
  logic       arrived_q, arrived_d;
  logic       cmd_error_q, cmd_error_d;

  logic [1:0] cmd_idx;
  logic       cmd_known;
  logic [1:0] step_pos;
  logic       tmr_load;
  logic [7:0] tmr_value;
  logic       tmr_done;

  // Map the external floor code onto the internal position index.
  always_comb begin
    cmd_idx   = IDX_F1;
    cmd_known = 1'b1;
    if (cmd_floor == FLOOR_INVALID) begin
      cmd_known = 1'b0;
    end else if (cmd_floor == labelF1) begin
      cmd_idx = IDX_F1;
    end else if (cmd_floor == labelF2) begin
      cmd_idx = IDX_F2;
    end else if (cmd_floor == labelF3) begin
      cmd_idx = IDX_F3;
    end else begin
      cmd_known = 1'b0;
    end
  end

  assign step_pos = dir_q ? (pos_q + 2'd1) : (pos_q - 2'd1);

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    target_d    = target_q;
    dir_d       = dir_q;
    arrived_d   = 1'b0;
    cmd_error_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_value   = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_known) begin
            cmd_error_d = 1'b1;
          end else if (cmd_idx == pos_q) begin
            state_d   = ST_DOOR_OPEN;
            arrived_d = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = DOOR_LOAD;
          end else begin
            state_d   = ST_MOVE;
            target_d  = cmd_idx;
            dir_d     = (cmd_idx > pos_q);
            tmr_load  = 1'b1;
            tmr_value = TRAVEL_LOAD;
          end
        end
      end
      ST_MOVE: begin
        if (tmr_done) begin
          pos_d    = step_pos;
          tmr_load = 1'b1;
          if (step_pos == target_q) begin
            state_d   = ST_DOOR_OPEN;
            arrived_d = 1'b1;
            tmr_value = DOOR_LOAD;
          end else begin
            tmr_value = TRAVEL_LOAD;
          end
        end
      end
      ST_DOOR_OPEN: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset wins over any command sampled on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pos_q       <= IDX_F1;
      target_q    <= IDX_F1;
      dir_q       <= 1'b0;
      arrived_q   <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      target_q    <= target_d;
      dir_q       <= dir_d;
      arrived_q   <= arrived_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  interval_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_value(tmr_value),
    .done      (tmr_done)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign moving    = (state_q == ST_MOVE);
  assign door      = (state_q == ST_DOOR_OPEN);
  assign dir_up    = dir_q;
  assign arrived   = arrived_q;
  assign cmd_error = cmd_error_q;
  assign floor1    = (pos_q == IDX_F1);
  assign floor2    = (pos_q == IDX_F2);
  assign floor3    = (pos_q == IDX_F3);

endmodule

// File: tb/tb_car_drive.sv
// Bench for car_drive: directed trips followed by random commands and resets,
// every cycle compared against a trip-timeline model.
module tb_car_drive;

  localparam int TRAVEL = 4;
  localparam int DOORC  = 3;

  logic       clk;
  logic       reset;
  logic       cmdValid;
  logic [1:0] cmdFloor;
  logic       cmdReady;
  logic       floor1, floor2, floor3;
  logic       moving, dirUp, door, arrived, cmdError;

  int checkCount = 0;
  int failCount  = 0;

  // Model: a trip is described by its start, target and edges since accept.
  int mActive = 0;
  int mN      = 0;
  int mStart  = 0;
  int mTarget = 0;
  int mPos    = 0;
  int mErr    = 0;

  car_drive #(
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOORC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmdValid),
    .cmd_floor(cmdFloor),
    .cmd_ready(cmdReady),
    .floor1   (floor1),
    .floor2   (floor2),
    .floor3   (floor3),
    .moving   (moving),
    .dir_up   (dirUp),
    .door     (door),
    .arrived  (arrived),
    .cmd_error(cmdError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input bit v, input int f, input bit r);
    int d;
    mErr = 0;
    if (r) begin
      mActive = 0;
      mPos    = 0;
    end else if (mActive == 0) begin
      if (v) begin
        if (f == 3) begin
          mErr = 1;
        end else begin
          mActive = 1;
          mStart  = mPos;
          mTarget = f;
          mN      = 0;
        end
      end
    end else begin
      mN++;
      d = (mTarget > mStart) ? mTarget - mStart : mStart - mTarget;
      if (mN >= d * TRAVEL + DOORC) begin
        mActive = 0;
        mPos    = mTarget;
      end
    end
  endtask

  task automatic checkAll();
    int d, steps, expPos, expMoving, expDoor, expArr, expReady, expDir;
    if (mActive != 0) begin
      d     = (mTarget > mStart) ? mTarget - mStart : mStart - mTarget;
      steps = mN / TRAVEL;
      if (steps > d) steps = d;
      expPos    = (mTarget >= mStart) ? mStart + steps : mStart - steps;
      expMoving = (mN < d * TRAVEL) ? 1 : 0;
      expDoor   = 1 - expMoving;
      expArr    = (mN == d * TRAVEL) ? 1 : 0;
      expReady  = 0;
      expDir    = (mTarget > mStart) ? 1 : 0;
    end else begin
      expPos    = mPos;
      expMoving = 0;
      expDoor   = 0;
      expArr    = 0;
      expReady  = 1;
      expDir    = 0;
    end
    checkOutput("floor1",    int'(floor1),   (expPos == 0) ? 1 : 0);
    checkOutput("floor2",    int'(floor2),   (expPos == 1) ? 1 : 0);
    checkOutput("floor3",    int'(floor3),   (expPos == 2) ? 1 : 0);
    checkOutput("moving",    int'(moving),   expMoving);
    checkOutput("door",      int'(door),     expDoor);
    checkOutput("arrived",   int'(arrived),  expArr);
    checkOutput("cmd_error", int'(cmdError), mErr);
    checkOutput("cmd_ready", int'(cmdReady), expReady);
    if (expMoving != 0) checkOutput("dir_up", int'(dirUp), expDir);
    checkOutput("onehot",    int'($onehot({floor1, floor2, floor3})), 1);
    checkOutput("door_move_excl", int'(door & moving), 0);
  endtask

  task automatic applyStimulus(input bit v, input int f, input bit r);
    @(negedge clk);
    cmdValid = v;
    cmdFloor = 2'(f);
    reset    = r;
    @(posedge clk);
    #1;
    modelStep(v, f, r);
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    cmdValid = 1'b0;
    cmdFloor = 2'b00;
    $display("[TB] starting car_drive bench");

    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b1);
    // Door request at the current floor, then an invalid code.
    applyStimulus(1'b1, 0, 1'b0);
    idleCycles(4);
    applyStimulus(1'b1, 3, 1'b0);
    idleCycles(2);
    // F1 -> F3 trip, then F3 -> F1.
    applyStimulus(1'b1, 2, 1'b0);
    idleCycles(12);
    applyStimulus(1'b1, 0, 1'b0);
    idleCycles(12);
    // Commands arriving while busy must be dropped.
    applyStimulus(1'b1, 2, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, i % 4, 1'b0);
    idleCycles(2);
    // Go back to F1, then abort an F1 -> F3 trip with reset at E0+5.
    applyStimulus(1'b1, 0, 1'b0);
    idleCycles(12);
    applyStimulus(1'b1, 2, 1'b0);
    idleCycles(4);
    applyStimulus(1'b0, 0, 1'b1);
    idleCycles(4);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0),
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
